// File: rtl/branch_predict_unit_if.sv
// IF/ID-facing bundle of branch_predict_unit; BRANCH_STATS_EN adds the stat counters.
// master = pipeline side driving lookup/resolve requests, slave = predictor.
interface branch_predict_unit_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic [PC_W-1:0] if_pc;
  logic            if_pred_taken;

  logic            id_valid;
  logic [PC_W-1:0] id_pc;
  logic [2:0]      id_funct3;
  logic [XLEN-1:0] id_rs1;
  logic [XLEN-1:0] id_rs2;
  logic            id_pred_taken;
  logic            stall;
  logic            flush;

  logic            res_valid;
  logic            res_taken;
  logic            res_mispredict;
  logic            res_illegal;
  logic [PC_W-1:0] res_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  modport master (
    output if_pc, id_valid, id_pc, id_funct3, id_rs1, id_rs2, id_pred_taken, stall, flush,
    input  if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal, res_pc
`ifdef BRANCH_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  if_pc, id_valid, id_pc, id_funct3, id_rs1, id_rs2, id_pred_taken, stall, flush,
    output if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal, res_pc
`ifdef BRANCH_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolve (1-cycle registered result) + 2-bit BHT; stall holds result and defers the update,
// flush drops it. Define BRANCH_STATS_EN for 32-bit branch/mispredict counters.
module branch_predict_unit #(
  parameter int         XLEN      = 32,
  parameter int         PC_W      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_en;
  logic [1:0]       upd_cnt_d;

  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic             res_illegal_q, res_illegal_d;
  logic [PC_W-1:0]  res_pc_q, res_pc_d;

  logic [XLEN:0]    diff;
  logic             is_eq;
  logic             is_lt_s;
  logic             is_lt_u;
  logic             cond_taken;
  logic             cond_illegal;
  logic             capture;
  logic             unused_pc_bits;

  // Tagless direct-mapped lookup: aliasing between PCs sharing an index is accepted.
  assign if_idx             = bus.if_pc[IDX_W+1:2];
  assign upd_idx            = res_pc_q[IDX_W+1:2];
  assign bus.if_pred_taken  = bht_q[if_idx][1];
  assign unused_pc_bits     = ^{bus.if_pc, res_pc_q};

  // One shared subtractor: bit XLEN is the unsigned borrow.
  assign diff    = {1'b0, bus.id_rs1} - {1'b0, bus.id_rs2};
  assign is_eq   = (diff[XLEN-1:0] == '0);
  assign is_lt_u = diff[XLEN];
  assign is_lt_s = (bus.id_rs1[XLEN-1] & ~bus.id_rs2[XLEN-1]) |
                   ((bus.id_rs1[XLEN-1] ~^ bus.id_rs2[XLEN-1]) & diff[XLEN-1]);

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (bus.id_funct3)
      F3_BEQ:  cond_taken = is_eq;
      F3_BNE:  cond_taken = ~is_eq;
      F3_BLT:  cond_taken = is_lt_s;
      F3_BGE:  cond_taken = ~is_lt_s;
      F3_BLTU: cond_taken = is_lt_u;
      F3_BGEU: cond_taken = ~is_lt_u;
      default: cond_illegal = 1'b1;
    endcase
  end

  assign capture = bus.id_valid & ~bus.stall & ~bus.flush;

  always_comb begin
    res_valid_d      = res_valid_q;
    res_taken_d      = res_taken_q;
    res_mispredict_d = res_mispredict_q;
    res_illegal_d    = res_illegal_q;
    res_pc_d         = res_pc_q;
    if (capture) begin
      res_valid_d      = 1'b1;
      res_taken_d      = cond_taken;
      res_mispredict_d = cond_taken ^ bus.id_pred_taken;
      res_illegal_d    = cond_illegal;
      res_pc_d         = bus.id_pc;
    end else if (bus.flush || !bus.stall) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_illegal_q    <= 1'b0;
      res_pc_q         <= '0;
    end else begin
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      res_illegal_q    <= res_illegal_d;
      res_pc_q         <= res_pc_d;
    end
  end

  assign bus.res_valid      = res_valid_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_mispredict = res_mispredict_q;
  assign bus.res_illegal    = res_illegal_q;
  assign bus.res_pc         = res_pc_q;

  // A held result updates only once, on the first cycle it is neither stalled nor flushed.
  assign upd_en = res_valid_q & ~res_illegal_q & ~bus.stall & ~bus.flush;

  always_comb begin
    upd_cnt_d = bht_q[upd_idx];
    if (res_taken_q && bht_q[upd_idx] != 2'b11) begin
      upd_cnt_d = bht_q[upd_idx] + 2'b01;
    end else if (!res_taken_q && bht_q[upd_idx] != 2'b00) begin
      upd_cnt_d = bht_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (upd_en) begin
      bht_q[upd_idx] <= upd_cnt_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_en) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (res_mispredict_q) begin
        stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: hand-computed results and counter trajectories.
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(32), .PC_W(32)) bif ();

  branch_predict_unit #(
    .XLEN(32), .PC_W(32), .BHT_DEPTH(64), .CNT_INIT(2'b01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp);
    bif.if_pc = pc;
    #1;
    chk(tag, {31'd0, bif.if_pred_taken}, {31'd0, exp});
  endtask

  task automatic br(input logic [31:0] pc, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b, input logic pred);
    bif.id_valid      = 1'b1;
    bif.id_pc         = pc;
    bif.id_funct3     = f3;
    bif.id_rs1        = a;
    bif.id_rs2        = b;
    bif.id_pred_taken = pred;
    step();
    bif.id_valid      = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic t, input logic m,
                         input logic il, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, bif.res_valid}, {31'd0, v});
    chk({tag, "_taken"}, {31'd0, bif.res_taken}, {31'd0, t});
    chk({tag, "_misp"},  {31'd0, bif.res_mispredict}, {31'd0, m});
    chk({tag, "_ill"},   {31'd0, bif.res_illegal}, {31'd0, il});
    chk({tag, "_pc"},    bif.res_pc, pc);
  endtask

  initial begin
    bif.if_pc = 32'h100;
    bif.id_valid = 1'b0;
    bif.id_pc = '0;
    bif.id_funct3 = '0;
    bif.id_rs1 = '0;
    bif.id_rs2 = '0;
    bif.id_pred_taken = 1'b0;
    bif.stall = 1'b0;
    bif.flush = 1'b0;
    #12;
    chk_res("rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    look("rst_pred", 32'h100, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rel_valid", {31'd0, bif.res_valid}, 32'd0);

    // BEQ equal, predicted not-taken: mispredict, counter 01 -> 10
    br(32'h100, 3'b000, 32'h5, 32'h5, 1'b0);
    chk_res("beq", 1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
    look("beq_old_pred", 32'h100, 1'b0);
    step();
    chk("beq_idle_valid", {31'd0, bif.res_valid}, 32'd0);
    look("beq_new_pred", 32'h100, 1'b1);

    // Comparator patterns, back to back on distinct indices
    br(32'h104, 3'b100, 32'hFFFF_FFFF, 32'h1, 1'b0);
    chk_res("blt", 1'b1, 1'b1, 1'b1, 1'b0, 32'h104);
    br(32'h108, 3'b110, 32'hFFFF_FFFF, 32'h1, 1'b1);
    chk_res("bltu", 1'b1, 1'b0, 1'b1, 1'b0, 32'h108);
    br(32'h10C, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    chk_res("bge", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10C);
    br(32'h110, 3'b111, 32'h1, 32'hFFFF_FFFF, 1'b0);
    chk_res("bgeu", 1'b1, 1'b0, 1'b0, 1'b0, 32'h110);
    br(32'h114, 3'b001, 32'h5, 32'h5, 1'b0);
    chk_res("bne_eq", 1'b1, 1'b0, 1'b0, 1'b0, 32'h114);
    br(32'h118, 3'b101, 32'h5, 32'hFFFF_FFFF, 1'b0);
    chk_res("bge_t", 1'b1, 1'b1, 1'b1, 1'b0, 32'h118);
    step();
    look("blt_pred", 32'h104, 1'b1);
    look("bltu_pred", 32'h108, 1'b0);
    look("bge_t_pred", 32'h118, 1'b1);

    // Saturation at 0x40: 01 -> 10 -> 11 -> 11 -> 11, then two not-taken -> 10 -> 01
    br(32'h40, 3'b001, 32'h1, 32'h2, 1'b0);
    chk("sat1_misp", {31'd0, bif.res_mispredict}, 32'd1);
    br(32'h40, 3'b001, 32'h1, 32'h2, 1'b1);
    br(32'h40, 3'b001, 32'h1, 32'h2, 1'b1);
    br(32'h40, 3'b001, 32'h1, 32'h2, 1'b1);
    chk("sat4_misp", {31'd0, bif.res_mispredict}, 32'd0);
    step();
    look("sat_pred", 32'h40, 1'b1);
    br(32'h40, 3'b001, 32'h7, 32'h7, 1'b1);
    chk_res("nt1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h40);
    step();
    look("nt1_pred", 32'h40, 1'b1);
    br(32'h40, 3'b001, 32'h7, 32'h7, 1'b1);
    step();
    look("nt2_pred", 32'h40, 1'b0);

    // Stall for three cycles with a competing branch in ID
    br(32'h80, 3'b000, 32'h3, 32'h3, 1'b0);
    bif.stall = 1'b1;
    bif.id_valid = 1'b1;
    bif.id_pc = 32'h84;
    bif.id_funct3 = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_res("stall", 1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
      look("stall_pred", 32'h80, 1'b0);
    end
    bif.stall = 1'b0;
    bif.id_valid = 1'b0;
    step();
    chk("unstall_valid", {31'd0, bif.res_valid}, 32'd0);
    look("unstall_pred", 32'h80, 1'b1);
    look("stall_no_cap", 32'h84, 1'b0);

    // Flush with a branch in ID: nothing captured, table untouched
    bif.flush = 1'b1;
    br(32'h88, 3'b000, 32'h1, 32'h1, 1'b0);
    chk("flush_valid", {31'd0, bif.res_valid}, 32'd0);
    bif.flush = 1'b0;
    step();
    look("flush_pred", 32'h88, 1'b0);

    // Flush overriding stall drops a pending update
    br(32'h8C, 3'b000, 32'h2, 32'h2, 1'b0);
    chk("pend_valid", {31'd0, bif.res_valid}, 32'd1);
    bif.stall = 1'b1;
    bif.flush = 1'b1;
    step();
    chk("fs_valid", {31'd0, bif.res_valid}, 32'd0);
    bif.stall = 1'b0;
    bif.flush = 1'b0;
    step();
    look("fs_pred", 32'h8C, 1'b0);

    // Illegal funct3: not taken, no update
    br(32'h90, 3'b010, 32'h4, 32'h4, 1'b1);
    chk_res("ill010", 1'b1, 1'b0, 1'b1, 1'b1, 32'h90);
    step();
    look("ill_pred", 32'h90, 1'b0);
    br(32'h94, 3'b011, 32'h4, 32'h9, 1'b0);
    chk_res("ill011", 1'b1, 1'b0, 1'b0, 1'b1, 32'h94);
    step();
`ifdef BRANCH_STATS_EN
    chk("stat_br", bif.stat_branches, 32'd14);
    chk("stat_mp", bif.stat_mispredicts, 32'd8);
`endif

    // Reset mid-operation: in-flight result and update lost, table reinitialised
    br(32'h40, 3'b001, 32'h1, 32'h2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_res("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    look("mid_rst_100", 32'h100, 1'b0);
    rst_n = 1'b1;
    step();
    look("mid_rst_40", 32'h40, 1'b0);
    look("mid_rst_104", 32'h104, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the RV32 pipeline. The ID stage presents a decoded conditional branch with its operands. The block evaluates the condition, registers the outcome and flags mispredicts against the prediction IF made. It owns a direct-mapped table of 2-bit saturating counters that IF queries each cycle. It sits between IF (prediction lookup) and ID/EX (resolution, flush request).

## Interface
- `XLEN`, 32, operand width (≥ 8)
- `PC_W`, 32, program-counter width
- `BHT_DEPTH`, 64, counter-table entries; power of two, 4..1024
- `CNT_INIT`, 2'b01, counter value after reset (weakly not-taken)

Ports:
- `clk` in 1: clock; all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `if_pc` in PC_W: fetch PC for lookup
- `if_pred_taken` out 1: prediction for `if_pc`, combinational from table
- `id_valid` in 1: ID holds a branch this cycle
- `id_pc` in PC_W: PC of the branch in ID
- `id_funct3` in 3: branch funct3
- `id_rs1`, `id_rs2` in XLEN: forwarded operands
- `id_pred_taken` in 1: prediction IF used for this branch
- `stall` in 1: hold result register, suppress update
- `flush` in 1: discard ID branch and clear result valid
- `res_valid` out 1: registered result valid
- `res_taken` out 1: resolved direction
- `res_mispredict` out 1: `res_taken` ≠ carried prediction
- `res_illegal` out 1: funct3 was 010 or 011
- `res_pc` out PC_W: PC of resolved branch

## Operation
- Index = `pc[log2(BHT_DEPTH)+1:2]`. Low two PC bits are ignored. No tags are kept, so aliasing is accepted.
- Prediction: `if_pred_taken` = counter[idx(if_pc)][1].
- Condition decode on `id_funct3`:
  - 000: EQ
  - 001: NE
  - 100: signed LT
  - 101: signed GE
  - 110: unsigned LT
  - 111: unsigned GE
  - 010, 011: not taken, `res_illegal`=1
- Compare via single XLEN+1-bit subtract `rs1 − rs2`:
  - Equality is zero detect.
  - Signed LT = (sign1 & ~sign2) | (sign1 ~^ sign2) & diff[XLEN-1].
  - Unsigned LT = borrow out.
- Capture occurs when `id_valid & ~stall & ~flush`. On capture, the result register loads taken, mispredict, illegal and pc, and `res_valid`=1. Otherwise, when not stalled, `res_valid`=0.
- Update: in the cycle `res_valid` & ~`res_illegal` & ~`stall`, counter[idx(res_pc)] moves ±1 toward `res_taken`, saturating at 00/11. Exactly one update per resolved branch. An illegal branch never updates.
- `flush` overrides `stall`: `res_valid` clears and the pending update is dropped.

## Timing
- Reset (async assert, sync release):
  - All `res_*` outputs are 0.
  - All counters = `CNT_INIT`.
  - `if_pred_taken` reads CNT_INIT[1].
- Resolve latency: 1 cycle, `id_*` at edge N → `res_*` valid after edge N.
- Update lands on edge N+1, visible to `if_pred_taken` after that edge.
- Same-index read and write in one cycle: IF sees the old value; there is no bypass.
- `stall`: `res_*` hold their values and no update occurs. The update fires on the first non-stalled cycle.
- Back-to-back branches with the same index: the second update uses the counter already modified by the first. The read-modify-write is serialised through the result register.
- Reset mid-operation: the in-flight result and update are lost, and the table reinitialises.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds outputs `stat_branches` and `stat_mispredicts`, both 32-bit.
  - Counters increment on each non-illegal update, and on updates with `res_mispredict` respectively.
  - They wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, `if_pc`=0x100 → `if_pred_taken`=0, `res_valid`=0.
- BEQ, rs1=rs2=0x5, pred 0, pc 0x100 → next cycle `res_taken`=1, `res_mispredict`=1. Entry 0x100 becomes 10, so `if_pred_taken`=1 one cycle later.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU, same operands → not taken. BGE rs1=0x80000000, rs2=0x7FFFFFFF → not taken.
- Four taken BNEs at pc 0x40 → counter saturates at 11. One not-taken → 10, prediction stays 1.
- `stall` held 3 cycles after a capture → `res_*` stable and no counter change; the update lands after stall drops. `flush` with `id_valid` → `res_valid`=0 and the table is unchanged.
- funct3=010 → `res_illegal`=1, `res_taken`=0, no update. With `BRANCH_STATS_EN`, `stat_branches` is unchanged.
